// File: rtl/hazard_scoreboard.sv
// Load-use and long-latency hazard scoreboard beside ID: tracks pending register
// writes from loads (fixed latency) and one optional multiply/divide op.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 1,
    parameter int LONG_EN  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] idata_ID,
    input  logic        flush,
    input  logic        lu_done,
    input  logic [4:0]  lu_rd,
    output logic        stall,
    output logic        issue,
    output logic        long_pending
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    logic [CW-1:0] r_cnt [1:NREG-1];
    logic          r_lp_valid;
    logic [4:0]    r_lp_rd;

    logic [6:0]  w_op;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_rd_wr;
    logic        w_is_load;
    logic        w_is_long;
    logic [31:0] w_busy;
    logic        w_stall;
    logic        w_issue;

    // A register is hazardous while a load counter runs or the long op targets it.
    function automatic logic f_haz(input logic [4:0] r, input logic [31:0] busy,
                                   input logic lpv, input logic [4:0] lprd);
        return (r != 5'd0) && (busy[r] || (lpv && (lprd == r)));
    endfunction

    assign w_op       = idata_ID[6:0];
    assign w_rs1      = idata_ID[19:15];
    assign w_rs2      = idata_ID[24:20];
    assign w_rd       = idata_ID[11:7];
    assign w_rs1_used = (w_op != OP_LUI) && (w_op != OP_AUIPC) && (w_op != OP_JAL);
    assign w_rs2_used = (w_op == OP_REG) || (w_op == OP_STORE) || (w_op == OP_BRANCH);
    assign w_rd_wr    = (w_op != OP_STORE) && (w_op != OP_BRANCH) && (w_rd != 5'd0);
    assign w_is_load  = (w_op == OP_LOAD);
    assign w_is_long  = (LONG_EN != 0) && (w_op == OP_REG) && (idata_ID[31:25] == F7_MULDIV);

    always_comb begin
        w_busy = '0;
        for (int i = 1; i < NREG; i++) begin
            w_busy[i] = (r_cnt[i] != '0);
        end
    end

    // WAW only needs checking against the long op: load counters are overwritten on issue.
    always_comb begin
        w_stall = 1'b0;
        if (id_valid && !flush) begin
            w_stall = (w_rs1_used && f_haz(w_rs1, w_busy, r_lp_valid, r_lp_rd))
                   || (w_rs2_used && f_haz(w_rs2, w_busy, r_lp_valid, r_lp_rd))
                   || (w_rd_wr && f_haz(w_rd, '0, r_lp_valid, r_lp_rd))
                   || (w_is_long && r_lp_valid);
        end
    end

    assign w_issue      = id_valid && !flush && !w_stall;
    assign stall        = w_stall;
    assign issue        = w_issue;
    assign long_pending = r_lp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_issue && w_rd_wr && (w_rd == 5'(i))) begin
                    r_cnt[i] <= w_is_load ? CW'(LOAD_LAT) : '0;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lp_valid <= 1'b0;
            r_lp_rd    <= 5'd0;
        end else begin
            if (w_issue && w_rd_wr && w_is_long) begin
                r_lp_valid <= 1'b1;
                r_lp_rd    <= w_rd;
            end else if (lu_done && r_lp_valid && (lu_rd == r_lp_rd)) begin
                r_lp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: instance A (LOAD_LAT=1, LONG_EN=0) and
// instance B (LOAD_LAT=3, LONG_EN=1) driven by a linear step sequence.
module tb_hazard_scoreboard;

    logic clk;
    logic rst;

    logic        a_valid, a_flush, a_done;
    logic [31:0] a_instr;
    logic [4:0]  a_lurd;
    logic        a_stall, a_issue, a_lp;

    logic        b_valid, b_flush, b_done;
    logic [31:0] b_instr;
    logic [4:0]  b_lurd;
    logic        b_stall, b_issue, b_lp;

    int n_checks = 0;
    int n_err    = 0;

    hazard_scoreboard #(.NREG(32), .LOAD_LAT(1), .LONG_EN(0)) u_a (
        .clk(clk), .rst(rst), .id_valid(a_valid), .idata_ID(a_instr), .flush(a_flush),
        .lu_done(a_done), .lu_rd(a_lurd), .stall(a_stall), .issue(a_issue),
        .long_pending(a_lp)
    );

    hazard_scoreboard #(.NREG(32), .LOAD_LAT(3), .LONG_EN(1)) u_b (
        .clk(clk), .rst(rst), .id_valid(b_valid), .idata_ID(b_instr), .flush(b_flush),
        .lu_done(b_done), .lu_rd(b_lurd), .stall(b_stall), .issue(b_issue),
        .long_pending(b_lp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd);
        return {20'h12345, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd);
        return enc_i(12'd0, 5'd1, 3'b010, rd, 7'b0000011);
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return enc_r(7'b0000000, rs2, rs1, rd);
    endfunction

    function automatic logic [31:0] mul(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return enc_r(7'b0000001, rs2, rs1, rd);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [31:0] ins, input logic fl);
        a_valid = v; a_instr = ins; a_flush = fl;
    endtask

    task automatic set_b(input logic v, input logic [31:0] ins, input logic fl,
                         input logic done, input logic [4:0] rd);
        b_valid = v; b_instr = ins; b_flush = fl; b_done = done; b_lurd = rd;
    endtask

    initial begin
        rst = 1'b1;
        a_done = 1'b0; a_lurd = 5'd0;
        set_a(1'b1, add(5'd6, 5'd5, 5'd7), 1'b0);
        set_b(1'b1, add(5'd6, 5'd5, 5'd7), 1'b0, 1'b0, 5'd0);
        #2;
        chk("rst_a_stall", a_stall, 1'b0);
        chk("rst_a_issue", a_issue, 1'b1);
        chk("rst_a_lp", a_lp, 1'b0);
        chk("rst_b_lp", b_lp, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---------------- instance A: LOAD_LAT=1 ----------------
        set_a(1'b1, lw(5'd5), 1'b0); #1;
        chk("a_lw_issue", a_issue, 1'b1);
        tick();
        set_a(1'b1, add(5'd6, 5'd5, 5'd7), 1'b0); #1;
        chk("a_lu_stall", a_stall, 1'b1);
        chk("a_lu_noissue", a_issue, 1'b0);
        tick();
        #1;
        chk("a_lu_stall_end", a_stall, 1'b0);
        chk("a_lu_issue", a_issue, 1'b1);
        tick();
        set_a(1'b1, lw(5'd5), 1'b0); tick();
        set_a(1'b1, enc_sw(5'd5, 5'd8), 1'b0); #1;
        chk("a_sw_rs2_stall", a_stall, 1'b1);
        tick();
        #1;
        chk("a_sw_issue", a_issue, 1'b1);
        tick();
        set_a(1'b1, lw(5'd0), 1'b0); tick();
        set_a(1'b1, add(5'd1, 5'd0, 5'd0), 1'b0); #1;
        chk("a_x0_nostall", a_stall, 1'b0);
        tick();
        set_a(1'b1, lw(5'd5), 1'b0); tick();
        set_a(1'b1, addi(5'd1, 5'd2, 12'h005), 1'b0); #1;
        chk("a_imm_field_nostall", a_stall, 1'b0);
        chk("a_imm_field_issue", a_issue, 1'b1);
        tick();
        set_a(1'b1, lw(5'd5), 1'b0); tick();
        set_a(1'b0, add(5'd6, 5'd5, 5'd7), 1'b0); #1;
        chk("a_invalid_nostall", a_stall, 1'b0);
        chk("a_invalid_noissue", a_issue, 1'b0);
        tick();
        set_a(1'b1, mul(5'd9, 5'd3, 5'd4), 1'b0); tick();
        set_a(1'b1, add(5'd1, 5'd9, 5'd2), 1'b0); #1;
        chk("a_mul_untracked_stall", a_stall, 1'b0);
        chk("a_mul_untracked_lp", a_lp, 1'b0);
        tick();
        set_a(1'b1, addi(5'd1, 5'd2, 12'd0), 1'b0); #1;
        chk("a_b2b_issue0", a_issue, 1'b1);
        tick(); #1;
        chk("a_b2b_issue1", a_issue, 1'b1);

        // ---------------- instance B: LOAD_LAT=3 ----------------
        set_b(1'b1, lw(5'd5), 1'b0, 1'b0, 5'd0); #1;
        chk("b_lw_issue", b_issue, 1'b1);
        tick();
        set_b(1'b1, addi(5'd1, 5'd5, 12'd1), 1'b0, 1'b0, 5'd0); #1;
        chk("b_lu_stall1", b_stall, 1'b1);
        tick(); #1;
        chk("b_lu_stall2", b_stall, 1'b1);
        tick(); #1;
        chk("b_lu_stall3", b_stall, 1'b1);
        tick(); #1;
        chk("b_lu_stall_end", b_stall, 1'b0);
        chk("b_lu_issue", b_issue, 1'b1);
        tick();
        set_b(1'b1, lw(5'd5), 1'b0, 1'b0, 5'd0); tick();
        set_b(1'b1, addi(5'd1, 5'd6, 12'd1), 1'b0, 1'b0, 5'd0); #1;
        chk("b_indep_nostall", b_stall, 1'b0);
        tick();
        set_b(1'b1, enc_lui(5'd5), 1'b0, 1'b0, 5'd0); #1;
        chk("b_lui_issue", b_issue, 1'b1);
        tick();
        set_b(1'b1, addi(5'd1, 5'd5, 12'd1), 1'b0, 1'b0, 5'd0); #1;
        chk("b_lui_cleared_cnt", b_stall, 1'b0);
        tick();

        set_b(1'b1, lw(5'd5), 1'b0, 1'b0, 5'd0); tick();
        set_b(1'b1, add(5'd6, 5'd5, 5'd7), 1'b1, 1'b0, 5'd0); #1;
        chk("b_flush_nostall", b_stall, 1'b0);
        chk("b_flush_noissue", b_issue, 1'b0);
        tick(); tick();
        b_flush = 1'b0; #1;
        chk("b_flush_cnt_last", b_stall, 1'b1);
        tick(); #1;
        chk("b_flush_cnt_done", b_issue, 1'b1);
        tick();

        set_b(1'b1, mul(5'd9, 5'd3, 5'd4), 1'b0, 1'b0, 5'd0); #1;
        chk("b_mul_issue", b_issue, 1'b1);
        tick();
        set_b(1'b1, add(5'd1, 5'd9, 5'd2), 1'b0, 1'b1, 5'd8); #1;
        chk("b_mul_lp", b_lp, 1'b1);
        chk("b_mul_dep_stall", b_stall, 1'b1);
        tick(); #1;
        chk("b_mismatch_done_lp", b_lp, 1'b1);
        b_done = 1'b0;
        b_instr = mul(5'd10, 5'd3, 5'd4); #1;
        chk("b_second_mul_stall", b_stall, 1'b1);
        b_instr = addi(5'd9, 5'd2, 12'd1); #1;
        chk("b_waw_stall", b_stall, 1'b1);
        set_b(1'b1, add(5'd1, 5'd9, 5'd2), 1'b0, 1'b1, 5'd9); #1;
        chk("b_done_cycle_stall", b_stall, 1'b1);
        tick();
        b_done = 1'b0; #1;
        chk("b_after_done_lp", b_lp, 1'b0);
        chk("b_after_done_issue", b_issue, 1'b1);
        tick();

        set_b(1'b1, mul(5'd9, 5'd3, 5'd4), 1'b0, 1'b0, 5'd0); tick();
        set_b(1'b1, mul(5'd11, 5'd3, 5'd4), 1'b0, 1'b1, 5'd9); #1;
        chk("b_conservative_stall", b_stall, 1'b1);
        tick();
        b_done = 1'b0; #1;
        chk("b_second_mul_issue", b_issue, 1'b1);
        tick();
        set_b(1'b1, lw(5'd5), 1'b0, 1'b0, 5'd0); tick();
        set_b(1'b1, addi(5'd1, 5'd2, 12'd0), 1'b0, 1'b0, 5'd0); tick();
        set_b(1'b1, add(5'd6, 5'd5, 5'd11), 1'b0, 1'b0, 5'd0); #1;
        chk("b_pre_rst_stall", b_stall, 1'b1);
        chk("b_pre_rst_lp", b_lp, 1'b1);
        rst = 1'b1; #1;
        chk("b_rst_stall", b_stall, 1'b0);
        chk("b_rst_issue", b_issue, 1'b1);
        chk("b_rst_lp", b_lp, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("b_post_rst_stall", b_stall, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
